// File: rtl/fsb_axis_packer.sv
// Packs 80-bit FSB packets four to a 512-bit AXI-Stream beat; partial beats flush on idle timeout or flush_i.
// Latency: 4th packet accepted in cycle t -> xfer in t+1 -> axis_tvalid_o in t+2.
// Backpressure: holds 8 packets (accumulator + output register); fsb_yumi_o drops when both are full and tready is low.
module fsb_axis_packer #(
  parameter int fsb_width_p     = 80,
  parameter int slot_width_p    = 128,
  parameter int axis_width_p    = 512,
  parameter int flush_timeout_p = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic                      fsb_v_i,
  input  logic [fsb_width_p-1:0]    fsb_data_i,
  output logic                      fsb_yumi_o,
  output logic                      axis_tvalid_o,
  output logic [axis_width_p-1:0]   axis_tdata_o,
  output logic [axis_width_p/8-1:0] axis_tkeep_o,
  output logic                      axis_tlast_o,
  input  logic                      axis_tready_i,
  output logic [31:0]               pkt_count_o,
  output logic [31:0]               beat_count_o
);

  localparam int slots_lp      = axis_width_p / slot_width_p;
  localparam int keep_width_lp = axis_width_p / 8;
  localparam int slot_bytes_lp = slot_width_p / 8;
  localparam int cnt_width_lp  = $clog2(slots_lp + 1);

  logic [cnt_width_lp-1:0]  r_slot_cnt;
  logic [31:0]              r_idle_cnt;
  logic                     r_flush_pending;
  logic [axis_width_p-1:0]  r_acc;
  logic                     r_out_v;
  logic                     r_out_last;
  logic [axis_width_p-1:0]  r_out_data;
  logic [keep_width_lp-1:0] r_out_keep;
  logic [31:0]              r_pkt_count;
  logic [31:0]              r_beat_count;

  logic                     w_full;
  logic                     w_xfer;
  logic                     w_yumi;
  logic                     w_handoff;
  logic                     w_nonempty_next;
  logic                     w_idle_clr;
  logic                     w_timeout_hit;
  logic [cnt_width_lp-1:0]  w_slot;
  logic [axis_width_p-1:0]  w_acc_next;
  logic [keep_width_lp-1:0] w_keep;

  assign w_full    = (r_slot_cnt == cnt_width_lp'(slots_lp));
  assign w_xfer    = (w_full | (r_flush_pending & (r_slot_cnt != '0))) & (~r_out_v | axis_tready_i);
  // Nothing is accepted while reset is asserted, so a packet can never slip past a reset.
  assign w_yumi    = ~reset_i & fsb_v_i & en_i & ~r_flush_pending & (~w_full | w_xfer);
  assign w_slot    = w_xfer ? '0 : r_slot_cnt;
  assign w_handoff = r_out_v & axis_tready_i;

  // A flush request only sticks if the accumulator still holds data after this cycle;
  // otherwise it would wait forever for a beat that can never be built.
  assign w_nonempty_next = w_yumi | ((r_slot_cnt != '0) & ~w_xfer);
  assign w_idle_clr      = w_yumi | (r_slot_cnt == '0) | r_flush_pending;
  assign w_timeout_hit   = (flush_timeout_p != 0) & ~w_idle_clr &
                           (r_idle_cnt == 32'(flush_timeout_p - 1));

  // Next accumulator: cleared on xfer, then the accepted packet lands in its slot (upper slot bits stay zero)
  always_comb begin
    w_acc_next = w_xfer ? '0 : r_acc;
    for (int n = 0; n < slots_lp; n++) begin
      if (w_yumi && (w_slot == cnt_width_lp'(n))) begin
        w_acc_next[n*slot_width_p +: fsb_width_p] = fsb_data_i;
      end
    end
  end

  // Byte enables for every slot currently filled in the accumulator
  always_comb begin
    w_keep = '0;
    for (int n = 0; n < slots_lp; n++) begin
      if (r_slot_cnt > cnt_width_lp'(n)) begin
        w_keep[n*slot_bytes_lp +: slot_bytes_lp] = '1;
      end
    end
  end

  // Accumulator, slot count, idle timer and pending-flush flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_acc           <= '0;
      r_slot_cnt      <= '0;
      r_idle_cnt      <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      if (w_yumi) begin
        r_slot_cnt <= w_slot + cnt_width_lp'(1);
      end else if (w_xfer) begin
        r_slot_cnt <= '0;
      end
      r_idle_cnt      <= w_idle_clr ? '0 : r_idle_cnt + 32'd1;
      r_flush_pending <= (r_flush_pending & ~w_xfer) |
                         ((flush_i | w_timeout_hit) & w_nonempty_next);
    end
  end

  // Output register: loads on xfer, holds while stalled, drops valid on handoff
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_out_v    <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
      r_out_keep <= '0;
    end else if (w_xfer) begin
      r_out_v    <= 1'b1;
      r_out_last <= r_flush_pending;
      r_out_data <= r_acc;
      r_out_keep <= w_keep;
    end else if (axis_tready_i) begin
      r_out_v    <= 1'b0;
    end
  end

  // Free-running packet and beat counters, wrapping modulo 2^32
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pkt_count  <= '0;
      r_beat_count <= '0;
    end else begin
      r_pkt_count  <= r_pkt_count + 32'(w_yumi);
      r_beat_count <= r_beat_count + 32'(w_handoff);
    end
  end

  assign fsb_yumi_o    = w_yumi;
  assign axis_tvalid_o = r_out_v;
  assign axis_tdata_o  = r_out_data;
  assign axis_tkeep_o  = r_out_keep;
  assign axis_tlast_o  = r_out_last;
  assign pkt_count_o   = r_pkt_count;
  assign beat_count_o  = r_beat_count;

endmodule

// File: tb/tb_fsb_axis_packer.sv
// Bench for fsb_axis_packer: queue-based reference model checked every cycle, plus directed scenarios.
// Latency: model tracks the two-stage pipe (accumulator, output register) per cycle.
// Backpressure: tready is driven low in directed and random phases to exercise the 8-packet capacity.
module tb_fsb_axis_packer;

  localparam int T = 16;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         en_i;
  logic         flush_i;
  logic         fsb_v_i;
  logic [79:0]  fsb_data_i;
  logic         fsb_yumi_o;
  logic         axis_tvalid_o;
  logic [511:0] axis_tdata_o;
  logic [63:0]  axis_tkeep_o;
  logic         axis_tlast_o;
  logic         axis_tready_i;
  logic [31:0]  pkt_count_o;
  logic [31:0]  beat_count_o;

  always #5 clk_i = ~clk_i;

  fsb_axis_packer #(
    .fsb_width_p(80), .slot_width_p(128), .axis_width_p(512), .flush_timeout_p(T)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .flush_i(flush_i),
    .fsb_v_i(fsb_v_i), .fsb_data_i(fsb_data_i), .fsb_yumi_o(fsb_yumi_o),
    .axis_tvalid_o(axis_tvalid_o), .axis_tdata_o(axis_tdata_o), .axis_tkeep_o(axis_tkeep_o),
    .axis_tlast_o(axis_tlast_o), .axis_tready_i(axis_tready_i),
    .pkt_count_o(pkt_count_o), .beat_count_o(beat_count_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: packets held as queues, beats formed from queue contents.
  logic [79:0] m_acc[$];
  logic [79:0] m_out[$];
  bit          m_fp, m_out_v, m_out_last, m_live;
  int          m_idle;
  logic [31:0] m_pkt, m_beat;
  int          cyc_n = 0;

  typedef struct {
    int           cyc;
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;
  int    yumi_log[$];
  beat_t beat_log[$];

  always @(negedge clk_i) begin
    logic [511:0] e_data;
    logic [63:0]  e_keep;
    bit           full, send, yumi, hit, nonempty, clr;
    int           n_old;
    beat_t        b;
    cyc_n++;
    n_old = m_acc.size();
    full  = (n_old == 4);
    send  = (full || (m_fp && n_old > 0)) && (!m_out_v || axis_tready_i);
    yumi  = !reset_i && fsb_v_i && en_i && !m_fp && (!full || send);
    if (m_live) begin
      e_data = '0;
      e_keep = '0;
      foreach (m_out[i]) begin
        e_data[i*128 +: 80] = m_out[i];
        e_keep[i*16 +: 16]  = 16'hFFFF;
      end
      chk("yumi",   512'(fsb_yumi_o),    512'(yumi));
      chk("tvalid", 512'(axis_tvalid_o), 512'(m_out_v));
      chk("tdata",  axis_tdata_o,        e_data);
      chk("tkeep",  512'(axis_tkeep_o),  512'(e_keep));
      chk("tlast",  512'(axis_tlast_o),  512'(m_out_last));
      chk("pkt_count",  512'(pkt_count_o),  512'(m_pkt));
      chk("beat_count", 512'(beat_count_o), 512'(m_beat));
    end
    if (reset_i) begin
      m_acc.delete();
      m_out.delete();
      m_fp = 0; m_out_v = 0; m_out_last = 0; m_idle = 0;
      m_pkt = '0; m_beat = '0;
      m_live = 1;
    end else if (m_live) begin
      if (fsb_yumi_o === 1'b1) yumi_log.push_back(cyc_n);
      if (axis_tvalid_o === 1'b1 && axis_tready_i) begin
        b.cyc = cyc_n; b.d = axis_tdata_o; b.k = axis_tkeep_o; b.l = axis_tlast_o;
        beat_log.push_back(b);
      end
      if (m_out_v && axis_tready_i) m_beat = m_beat + 32'd1;
      nonempty = yumi || (n_old > 0 && !send);
      clr      = yumi || (n_old == 0) || m_fp;
      hit      = !clr && (m_idle == T - 1);
      m_idle   = clr ? 0 : m_idle + 1;
      if (send) begin
        m_out      = m_acc;
        m_out_last = m_fp;
        m_out_v    = 1;
        m_acc.delete();
      end else if (m_out_v && axis_tready_i) begin
        m_out_v = 0;
      end
      m_fp = (m_fp && !send) || ((flush_i || hit) && nonempty);
      if (yumi) begin
        m_acc.push_back(fsb_data_i);
        m_pkt = m_pkt + 32'd1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1; fsb_v_i = 1'b0; flush_i = 1'b0; en_i = 1'b1;
    cyc(1);
    reset_i = 1'b0;
    yumi_log.delete();
    beat_log.delete();
  endtask

  // Offer consecutive packets base, base+1, ... advancing only when consumed.
  task automatic offer(input logic [79:0] base, input int n, input int budget, output int sent);
    sent = 0;
    for (int c = 0; c < budget && sent < n; c++) begin
      fsb_v_i    = 1'b1;
      fsb_data_i = base + 80'(sent);
      @(negedge clk_i);
      if (fsb_yumi_o === 1'b1) sent++;
      @(posedge clk_i);
      #1;
    end
    fsb_v_i = 1'b0;
  endtask

  initial begin
    int           sent, sent2, dly;
    logic [511:0] exp_d;
    logic [95:0]  rnd;
    int           ph;
    reset_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; fsb_v_i = 1'b0;
    fsb_data_i = '0; axis_tready_i = 1'b1;
    cyc(2);
    reset_i = 1'b0;
    chk("rst_tvalid", 512'(axis_tvalid_o), 512'(0));
    chk("rst_pkt",    512'(pkt_count_o),   512'(0));

    // 8 back-to-back packets with tready high
    do_reset();
    axis_tready_i = 1'b1;
    offer(80'h1, 8, 20, sent);
    cyc(6);
    chk("s1_sent",  512'(sent), 512'(8));
    chk("s1_yumis", 512'(yumi_log.size()), 512'(8));
    chk("s1_beats", 512'(beat_log.size()), 512'(2));
    if (yumi_log.size() == 8 && beat_log.size() == 2) begin
      chk("s1_yumi_run", 512'(yumi_log[7] - yumi_log[0]), 512'(7));
      chk("s1_lat",      512'(beat_log[0].cyc - yumi_log[3]), 512'(2));
      exp_d = '0;
      for (int n = 0; n < 4; n++) exp_d[n*128 +: 80] = 80'(n + 1);
      chk("s1_beat0",    beat_log[0].d, exp_d);
      chk("s1_b1_slot3", 512'(beat_log[1].d[463:384]), 512'(8));
      chk("s1_keep0",    512'(beat_log[0].k), 512'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("s1_keep1",    512'(beat_log[1].k), 512'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("s1_last",     512'({beat_log[0].l, beat_log[1].l}), 512'(0));
    end
    chk("s1_pkt",  512'(pkt_count_o),  512'(8));
    chk("s1_beat", 512'(beat_count_o), 512'(2));

    // tready low, 12 packets offered: only 8 fit
    do_reset();
    axis_tready_i = 1'b0;
    offer(80'h100, 12, 20, sent);
    chk("s2_sent",   512'(sent), 512'(8));
    chk("s2_pkt",    512'(pkt_count_o), 512'(8));
    chk("s2_tvalid", 512'(axis_tvalid_o), 512'(1));
    chk("s2_nobeat", 512'(beat_log.size()), 512'(0));
    axis_tready_i = 1'b1;
    offer(80'h108, 4, 20, sent2);
    cyc(10);
    chk("s2_sent2", 512'(sent2), 512'(4));
    chk("s2_beats", 512'(beat_log.size()), 512'(3));
    if (beat_log.size() == 3) begin
      for (int b = 0; b < 3; b++)
        for (int n = 0; n < 4; n++)
          chk($sformatf("s2_b%0d_s%0d", b, n), 512'(beat_log[b].d[n*128 +: 80]), 512'(32'h100 + b*4 + n));
    end

    // idle timeout with 2 packets
    do_reset();
    offer(80'hA1, 2, 5, sent);
    cyc(25);
    chk("s3_beats", 512'(beat_log.size()), 512'(1));
    if (beat_log.size() == 1 && yumi_log.size() == 2) begin
      dly = beat_log[0].cyc - yumi_log[1];
      chk("s3_delay_17_18", 512'(dly >= 17 && dly <= 18), 512'(1));
      chk("s3_keep",  512'(beat_log[0].k), 512'(64'h0000_0000_FFFF_FFFF));
      chk("s3_last",  512'(beat_log[0].l), 512'(1));
      chk("s3_upper", 512'(beat_log[0].d[511:256]), 512'(0));
      chk("s3_slot1", 512'(beat_log[0].d[207:128]), 512'(80'hA2));
    end

    // flush_i: empty, 3 packets, and with the 4th packet
    do_reset();
    flush_i = 1'b1; cyc(1); flush_i = 1'b0;
    cyc(5);
    chk("s4_empty_beat", 512'(beat_count_o), 512'(0));
    offer(80'hB0, 3, 6, sent);
    flush_i = 1'b1; cyc(1); flush_i = 1'b0;
    cyc(4);
    chk("s4_beats3", 512'(beat_log.size()), 512'(1));
    if (beat_log.size() == 1) begin
      chk("s4_keep3", 512'(beat_log[0].k), 512'(64'h0000_FFFF_FFFF_FFFF));
      chk("s4_last3", 512'(beat_log[0].l), 512'(1));
    end
    beat_log.delete();
    offer(80'hC0, 3, 6, sent);
    fsb_v_i = 1'b1; fsb_data_i = 80'hC3; flush_i = 1'b1;
    cyc(1);
    fsb_v_i = 1'b0; flush_i = 1'b0;
    cyc(4);
    chk("s4_beats4", 512'(beat_log.size()), 512'(1));
    if (beat_log.size() == 1) begin
      chk("s4_keep4",  512'(beat_log[0].k), 512'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("s4_last4",  512'(beat_log[0].l), 512'(1));
      chk("s4_slot3",  512'(beat_log[0].d[463:384]), 512'(80'hC3));
    end

    // reset while a beat is held and 2 slots are filled
    do_reset();
    axis_tready_i = 1'b0;
    offer(80'hD0, 6, 10, sent);
    chk("s5_sent",   512'(sent), 512'(6));
    chk("s5_tvalid", 512'(axis_tvalid_o), 512'(1));
    reset_i = 1'b1; cyc(1); reset_i = 1'b0;
    chk("s5_tvalid0", 512'(axis_tvalid_o), 512'(0));
    chk("s5_tdata0",  axis_tdata_o, 512'(0));
    chk("s5_tkeep0",  512'(axis_tkeep_o), 512'(0));
    chk("s5_counts0", 512'({pkt_count_o, beat_count_o}), 512'(0));
    axis_tready_i = 1'b1;
    cyc(30);
    chk("s5_nobeat", 512'(beat_log.size()), 512'(0));
    chk("s5_beat0",  512'(beat_count_o), 512'(0));

    // en_i low blocks acceptance; timeout still flushes
    do_reset();
    offer(80'hE1, 1, 4, sent);
    en_i = 1'b0; fsb_v_i = 1'b1; fsb_data_i = 80'hEE;
    cyc(25);
    fsb_v_i = 1'b0; en_i = 1'b1;
    chk("s6_yumis", 512'(yumi_log.size()), 512'(1));
    chk("s6_beats", 512'(beat_log.size()), 512'(1));
    if (beat_log.size() == 1) begin
      chk("s6_keep", 512'(beat_log[0].k), 512'(64'hFFFF));
      chk("s6_last", 512'(beat_log[0].l), 512'(1));
      chk("s6_data", 512'(beat_log[0].d[79:0]), 512'(80'hE1));
    end

    // randomized traffic, checked every cycle by the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ph  = (c / 150) % 3;
      rnd = {$urandom(), $urandom(), $urandom()};
      fsb_data_i    = rnd[79:0];
      fsb_v_i       = (ph == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      en_i          = $urandom_range(0, 9) != 0;
      axis_tready_i = (ph == 2) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 3) != 0);
      flush_i       = $urandom_range(0, 40) == 0;
      reset_i       = $urandom_range(0, 700) == 0;
      cyc(1);
    end
    reset_i = 1'b0; fsb_v_i = 1'b0; flush_i = 1'b0; en_i = 1'b1; axis_tready_i = 1'b1;
    cyc(40);
    chk("end_drained", 512'(axis_tvalid_o), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
